// File: rtl/spart_tx.sv
// Serial transmitter: one holding byte plus one shift register, framed as start/data/parity/stop.
// Bit timing comes entirely from tx_enable ticks; writes are refused (and flagged) while holding is full.
module spart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       wr,
    input  logic [7:0] data_in,
    input  logic       clr_ovr,
    output logic       txd,
    output logic       tbr,
    output logic       busy,
    output logic       ovr
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       par_q, par_d;
    logic       txd_q, txd_d;
    logic       ovr_q, ovr_d;
    logic       load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        stop_cnt_d  = stop_cnt_q;
        par_d       = par_q;
        txd_d       = txd_q;
        ovr_d       = ovr_q;
        load        = 1'b0;

        if (tx_enable) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_full_q) load = 1'b1;
                end
                S_START: begin
                    state_d = S_DATA;
                    cnt_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BIT) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b1;
                end
                S_STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        // Reload straight into START so back-to-back frames have no idle gap
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end

        if (load) begin
            state_d     = S_START;
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ (PARITY == 2);
            hold_full_d = 1'b0;
            txd_d       = 1'b0;
        end

        // Acceptance uses the pre-transfer holding state; a set from a dropped write beats a clear
        if (clr_ovr) ovr_d = 1'b0;
        if (wr) begin
            if (hold_full_q) begin
                ovr_d = 1'b1;
            end else begin
                hold_d      = data_in & DATA_MASK;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            cnt_q       <= 3'd0;
            stop_cnt_q  <= 1'b0;
            par_q       <= 1'b0;
            txd_q       <= 1'b1;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            par_q       <= par_d;
            txd_q       <= txd_d;
            ovr_q       <= ovr_d;
        end
    end

    assign txd  = txd_q;
    assign tbr  = ~hold_full_q;
    assign busy = (state_q != S_IDLE);
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_spart_tx.sv
// Four transmitter configurations driven by shared stimulus; each has a frame-queue reference
// model, a per-cycle flag check and a line receiver that decodes txd and scores whole frames.
module tb_spart_tx;

    localparam int NDUT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tx_enable = 1'b0;
    logic             wr = 1'b0;
    logic             clr_ovr = 1'b0;
    logic [7:0]       data_in = 8'd0;
    logic [NDUT-1:0]  txd_w, tbr_w, busy_w, ovr_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // g0: 8N1, g1: 8E1, g2: 7O1, g3: 7N2
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DB   = (g < 2) ? 8 : 7;
        localparam int PAR  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int SB   = (g == 3) ? 2 : 1;
        localparam int FLEN = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam logic [7:0] MASK = 8'((1 << DB) - 1);

        spart_tx #(.DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_enable (tx_enable),
            .wr        (wr),
            .data_in   (data_in),
            .clr_ovr   (clr_ovr),
            .txd       (txd_w[g]),
            .tbr       (tbr_w[g]),
            .busy      (busy_w[g]),
            .ovr       (ovr_w[g])
        );

        logic        m_full;
        logic [7:0]  m_hold;
        logic        m_ovr;
        logic [11:0] m_frm;
        int          m_len;
        bit          tick_last;
        logic [7:0]  expq[$];
        int          rpos = 0;
        logic [7:0]  rdat;
        logic        rpar;

        function automatic bit par_of(input logic [7:0] v);
            int ones;
            ones = $countones(v);
            if (PAR == 1) return (ones % 2) == 1;
            return (ones % 2) == 0;
        endfunction

        // Reference: the line plays out a queue of frame bits; holding refills it when it runs dry
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_full = 1'b0; m_hold = 8'd0; m_ovr = 1'b0;
                m_frm = '0; m_len = 0; tick_last = 1'b0;
                expq.delete();
            end else begin
                bit acc, drop;
                acc  = wr && !m_full;
                drop = wr && m_full;
                tick_last = tx_enable;
                if (tx_enable) begin
                    if (m_len > 0) begin
                        m_frm = m_frm >> 1;
                        m_len--;
                    end
                    if (m_len == 0 && m_full) begin
                        m_frm = '0;
                        for (int i = 0; i < DB; i++) m_frm[1+i] = m_hold[i];
                        if (PAR != 0) m_frm[1+DB] = par_of(m_hold);
                        for (int i = 0; i < SB; i++) m_frm[FLEN-SB+i] = 1'b1;
                        m_len  = FLEN;
                        m_full = 1'b0;
                        expq.push_back(m_hold);
                    end
                end
                if (acc) begin
                    m_full = 1'b1;
                    m_hold = data_in & MASK;
                end
                if (clr_ovr) m_ovr = 1'b0;
                if (drop) m_ovr = 1'b1;
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("d%0d txd", g), int'(txd_w[g]), (m_len > 0) ? int'(m_frm[0]) : 1);
                chk($sformatf("d%0d tbr", g), int'(tbr_w[g]), int'(!m_full));
                chk($sformatf("d%0d busy", g), int'(busy_w[g]), int'(m_len > 0));
                chk($sformatf("d%0d ovr", g), int'(ovr_w[g]), int'(m_ovr));
                if (tick_last) begin
                    if (rpos == 0) begin
                        if (txd_w[g] == 1'b0) begin
                            rpos = 1;
                            rdat = 8'd0;
                        end
                    end else begin
                        if (rpos <= DB) rdat[rpos-1] = txd_w[g];
                        else if (PAR != 0 && rpos == DB + 1) rpar = txd_w[g];
                        else chk($sformatf("d%0d stop bit", g), int'(txd_w[g]), 1);
                        if (rpos == FLEN - 1) begin
                            chk($sformatf("d%0d frame expected", g), int'(expq.size() > 0), 1);
                            if (expq.size() > 0) begin
                                logic [7:0] e;
                                e = expq.pop_front();
                                chk($sformatf("d%0d frame data", g), int'(rdat), int'(e));
                                if (PAR != 0)
                                    chk($sformatf("d%0d parity bit", g), int'(rpar), int'(par_of(e)));
                            end
                            rpos = 0;
                        end else begin
                            rpos++;
                        end
                    end
                end
            end else begin
                rpos = 0;
            end
        end
    end

    task automatic drive(input bit te, input bit w, input logic [7:0] d, input bit c);
        tx_enable = te; wr = w; data_in = d; clr_ovr = c;
        @(posedge clk); #1;
        tx_enable = 1'b0; wr = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int per);
        repeat (n) begin
            drive(1'b1, 1'b0, 8'd0, 1'b0);
            repeat (per - 1) drive(1'b0, 1'b0, 8'd0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " txd"}, int'(txd_w), 4'hF);
        chk({tag, " tbr"}, int'(tbr_w), 4'hF);
        chk({tag, " busy"}, int'(busy_w), 0);
        chk({tag, " ovr"}, int'(ovr_w), 0);
    endtask

    task automatic pulse_reset_midcycle();
        #2 rst = 1'b0;
        #1 check_reset_outputs("async reset");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int burst;
        burst = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        // 0x55 at one tick per four clocks, then parity pattern 0x07
        drive(1'b0, 1'b1, 8'h55, 1'b0);
        chk("tbr after write", int'(tbr_w), 0);
        run_ticks(14, 4);
        drive(1'b0, 1'b1, 8'h07, 1'b0);
        run_ticks(14, 4);

        // Second byte written while the first is in its data bits
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        run_ticks(3, 4);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        run_ticks(30, 4);

        // Three writes without a tick: only the first is taken
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        drive(1'b0, 1'b1, 8'h22, 1'b0);
        drive(1'b0, 1'b1, 8'h33, 1'b0);
        chk("ovr after drops", int'(ovr_w), 4'hF);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovr after clear", int'(ovr_w), 0);
        drive(1'b0, 1'b1, 8'h44, 1'b1);
        chk("ovr set beats clear", int'(ovr_w), 4'hF);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        run_ticks(30, 4);

        // Abort 0xFF during data bit 3, then a clean frame written right after release
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        run_ticks(5, 4);
        chk("busy before abort", int'(busy_w), 4'hF);
        pulse_reset_midcycle();
        drive(1'b0, 1'b1, 8'h01, 1'b0);
        chk("write after release taken", int'(tbr_w), 0);
        run_ticks(16, 4);

        for (int k = 0; k < 3000; k++) begin
            bit te;
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(2, 12);
            te = (burst > 0) || ($urandom_range(0, 3) == 0);
            if (burst > 0) burst--;
            drive(te, $urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 39) == 0);
            if (k == 1500) pulse_reset_midcycle();
        end

        for (int k = 0; k < 200 && !(busy_w == '0 && tbr_w == '1); k++)
            drive(1'b1, 1'b0, 8'd0, 1'b0);
        chk("drain busy", int'(busy_w), 0);
        chk("drain tbr", int'(tbr_w), 4'hF);
        chk("d0 frames left", g_dut[0].expq.size(), 0);
        chk("d1 frames left", g_dut[1].expq.size(), 0);
        chk("d2 frames left", g_dut[2].expq.size(), 0);
        chk("d3 frames left", g_dut[3].expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
